// File: rtl/text_console_writer_pkg.sv
// Shared constants, cell layout and state encodings for the 40x30 text console writer.
package text_console_pkg;

    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 11;

    // Video-RAM cell word layout
    localparam int CURSOR    = 14;
    localparam int BLINK     = 13;
    localparam int INVERTED  = 12;
    localparam int RGB_HI    = 11;
    localparam int RGB_LO    = 9;
    localparam int INTENSITY = 8;
    localparam int CHAR_HI   = 7;
    localparam int CHAR_LO   = 0;

    localparam logic [15:0] CURSOR_MASK = 16'(1) << CURSOR;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [3:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE_CHAR,
        S_CUR_OFF_RD,
        S_CUR_OFF_WR,
        S_SCROLL_RD,
        S_SCROLL_WR,
        S_SCROLL_BLANK,
        S_CUR_ON_RD,
        S_CUR_ON_WR
    } state_e;

    // Cursor move applied when the sequence reaches CUR_ON_RD
    typedef enum logic [2:0] {
        OP_HOME,
        OP_PRINT,
        OP_CR,
        OP_LF,
        OP_BS
    } op_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_writer.sv
// ASCII stream to video-RAM writer: cursor, wrap, CR/LF/BS/FF and hardware scroll.
// RAM port outputs are registered; each state's bus operation appears the cycle after it.
module text_console_writer
    import text_console_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [5:0]  char_attr,
    output logic        char_ready,
    output logic        busy,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        we,
    output logic [10:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic [15:0] ret_data
);

    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'(CELLS - COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(COLS);
    localparam logic [5:0]        COL_LAST   = 6'(COLS - 1);
    localparam logic [4:0]        ROW_LAST   = 5'(ROWS - 1);

    state_e              r_state, w_state_nxt;
    op_e                 r_op, w_op_nxt;
    logic [7:0]          r_char, w_char_nxt;
    logic [5:0]          r_attr, w_attr_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]   r_cur, w_cur_nxt;
    logic [5:0]          r_col, w_col_nxt;
    logic [4:0]          r_row, w_row_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_maddr_nxt;
    logic [15:0]         r_mem_data, w_mdata_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_CLEAR;
            r_op       <= OP_HOME;
            r_char     <= '0;
            r_attr     <= '0;
            r_addr     <= '0;
            r_cur      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_char     <= w_char_nxt;
            r_attr     <= w_attr_nxt;
            r_addr     <= w_addr_nxt;
            r_cur      <= w_cur_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_we       <= w_we_nxt;
            r_mem_addr <= w_maddr_nxt;
            r_mem_data <= w_mdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_char_nxt  = r_char;
        w_attr_nxt  = r_attr;
        w_addr_nxt  = r_addr;
        w_we_nxt    = 1'b0;
        w_maddr_nxt = r_mem_addr;
        w_mdata_nxt = r_mem_data;
        case (r_state)
            S_CLEAR: begin
                w_we_nxt    = 1'b1;
                w_maddr_nxt = r_addr;
                w_mdata_nxt = '0;
                if (r_addr == LAST_CELL) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_CUR_ON_RD;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            S_IDLE: begin
                if (char_valid) begin
                    w_char_nxt = char_data;
                    w_attr_nxt = char_attr;
                    if (is_printable(char_data)) begin
                        w_op_nxt    = OP_PRINT;
                        w_state_nxt = S_WRITE_CHAR;
                    end else begin
                        case (char_data)
                            CH_CR: begin
                                w_op_nxt    = OP_CR;
                                w_state_nxt = S_CUR_OFF_RD;
                            end
                            CH_LF: begin
                                w_op_nxt    = OP_LF;
                                w_state_nxt = S_CUR_OFF_RD;
                            end
                            CH_BS: begin
                                if (r_col != '0) begin
                                    w_op_nxt    = OP_BS;
                                    w_state_nxt = S_CUR_OFF_RD;
                                end
                            end
                            CH_FF: begin
                                w_op_nxt    = OP_HOME;
                                w_addr_nxt  = '0;
                                w_state_nxt = S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_WRITE_CHAR: begin
                w_we_nxt = 1'b1;
                if (r_op == OP_BS) begin
                    // Backspace lands one cell left and carries the cursor bit itself
                    w_maddr_nxt = r_cur - 1'b1;
                    w_mdata_nxt = {1'b0, 1'b1, r_attr, 8'h00};
                    w_state_nxt = S_CUR_ON_RD;
                end else begin
                    w_maddr_nxt = r_cur;
                    w_mdata_nxt = {2'b00, r_attr, r_char};
                    if (r_col == COL_LAST && r_row == ROW_LAST) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = S_SCROLL_RD;
                    end else begin
                        w_state_nxt = S_CUR_ON_RD;
                    end
                end
            end
            S_CUR_OFF_RD: begin
                w_maddr_nxt = r_cur;
                w_state_nxt = S_CUR_OFF_WR;
            end
            S_CUR_OFF_WR: begin
                w_we_nxt    = 1'b1;
                w_maddr_nxt = r_cur;
                w_mdata_nxt = ret_data & ~CURSOR_MASK;
                if (r_op == OP_BS) begin
                    w_state_nxt = S_WRITE_CHAR;
                end else if (r_op == OP_LF && r_row == ROW_LAST) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_SCROLL_RD;
                end else begin
                    w_state_nxt = S_CUR_ON_RD;
                end
            end
            S_SCROLL_RD: begin
                // r_addr is the destination; source is one row below
                w_maddr_nxt = r_addr + ROW_STRIDE;
                w_state_nxt = S_SCROLL_WR;
            end
            S_SCROLL_WR: begin
                w_we_nxt    = 1'b1;
                w_maddr_nxt = r_addr;
                w_mdata_nxt = ret_data & ~CURSOR_MASK;
                w_addr_nxt  = r_addr + 1'b1;
                w_state_nxt = (r_addr == SCROLL_END) ? S_SCROLL_BLANK : S_SCROLL_RD;
            end
            S_SCROLL_BLANK: begin
                w_we_nxt    = 1'b1;
                w_maddr_nxt = r_addr;
                w_mdata_nxt = '0;
                if (r_addr == LAST_CELL) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_CUR_ON_RD;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                end
            end
            S_CUR_ON_RD: begin
                w_maddr_nxt = r_cur;
                w_state_nxt = S_CUR_ON_WR;
            end
            S_CUR_ON_WR: begin
                w_we_nxt    = 1'b1;
                w_maddr_nxt = r_cur;
                w_mdata_nxt = ret_data | CURSOR_MASK;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // The pending move is committed on entry to CUR_ON_RD
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        w_cur_nxt = r_cur;
        if (w_state_nxt == S_CUR_ON_RD) begin
            case (r_op)
                OP_HOME: begin
                    w_col_nxt = '0;
                    w_row_nxt = '0;
                    w_cur_nxt = '0;
                end
                OP_PRINT: begin
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (r_row == ROW_LAST) begin
                            w_cur_nxt = r_cur - {5'd0, r_col};
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                            w_cur_nxt = r_cur + 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                        w_cur_nxt = r_cur + 1'b1;
                    end
                end
                OP_CR: begin
                    w_col_nxt = '0;
                    w_cur_nxt = r_cur - {5'd0, r_col};
                end
                OP_LF: begin
                    if (r_row != ROW_LAST) begin
                        w_row_nxt = r_row + 1'b1;
                        w_cur_nxt = r_cur + ROW_STRIDE;
                    end
                end
                OP_BS: begin
                    w_col_nxt = r_col - 1'b1;
                    w_cur_nxt = r_cur - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign char_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign we         = r_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench: a screen model queues every expected RAM write, a monitor pops on each write.
module tb_text_console_writer;
    import text_console_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic [5:0]  char_attr = 6'h00;
    logic        char_ready, busy, we;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [10:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] ret_data = 16'h0000;

    text_console_writer dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_attr  (char_attr),
        .char_ready (char_ready),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .we         (we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .ret_data   (ret_data)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] ram   [0:CELLS-1];
    logic [15:0] m_mem [0:CELLS-1];
    int          m_col = 0, m_row = 0;
    int          n_checks = 0, n_fail = 0;
    int          wr_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Video RAM: samples the port on the falling edge
    always @(negedge sys_clk) begin
        if (we) begin
            if (mem_addr < 11'(CELLS)) ram[mem_addr] <= mem_data;
        end else begin
            ret_data <= (mem_addr < 11'(CELLS)) ? ram[mem_addr] : 16'h0000;
        end
    end

    // Monitor: every write the DUT performs must be the next one the model expects
    always @(negedge sys_clk) begin
        if (sys_rst_n && we) begin
            wr_t e;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ram_write: unexpected write addr %0d data 0x%h", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                chk("ram_write", {5'd0, mem_addr, mem_data}, {5'd0, e.addr, e.data});
            end
        end
    end

    // ---- screen model ----
    task automatic exp_wr(input int a, input logic [15:0] d);
        wr_t w;
        w.addr = 11'(a);
        w.data = d;
        exp_q.push_back(w);
        m_mem[a] = d;
    endtask

    function automatic int m_cur();
        return m_row * COLS + m_col;
    endfunction

    task automatic m_cur_on();
        exp_wr(m_cur(), m_mem[m_cur()] | 16'h4000);
    endtask

    task automatic m_cur_off();
        exp_wr(m_cur(), m_mem[m_cur()] & 16'hBFFF);
    endtask

    task automatic m_clear();
        for (int a = 0; a < CELLS; a++) exp_wr(a, 16'h0000);
        m_col = 0;
        m_row = 0;
        m_cur_on();
    endtask

    task automatic m_scroll();
        for (int a = COLS; a < CELLS; a++) exp_wr(a - COLS, m_mem[a] & 16'hBFFF);
        for (int a = CELLS - COLS; a < CELLS; a++) exp_wr(a, 16'h0000);
    endtask

    task automatic m_byte(input logic [7:0] ch, input logic [5:0] at);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            exp_wr(m_cur(), {2'b00, at, ch});
            if (m_col == COLS - 1) begin
                m_col = 0;
                if (m_row == ROWS - 1) m_scroll();
                else m_row++;
            end else begin
                m_col++;
            end
            m_cur_on();
        end else if (ch == 8'h0D) begin
            m_cur_off();
            m_col = 0;
            m_cur_on();
        end else if (ch == 8'h0A) begin
            m_cur_off();
            if (m_row == ROWS - 1) m_scroll();
            else m_row++;
            m_cur_on();
        end else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_cur_off();
                m_col--;
                exp_wr(m_cur(), {2'b01, at, 8'h00});
                m_cur_on();
            end
        end else if (ch == 8'h0C) begin
            m_clear();
        end
    endtask

    // ---- stimulus helpers ----
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ch, input logic [5:0] at);
        int n = 0;
        while (!char_ready && n < 3000) begin
            tick();
            n++;
        end
        chk("ready_before_send", 32'(char_ready), 32'd1);
        m_byte(ch, at);
        char_valid = 1'b1;
        char_data  = ch;
        char_attr  = at;
        tick();
        char_valid = 1'b0;
    endtask

    // Junk is offered while busy; it must be ignored
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 3000) begin
            char_valid = 1'b1;
            char_data  = 8'($urandom);
            char_attr  = 6'($urandom);
            tick();
            n++;
        end
        char_valid = 1'b0;
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic settle();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic put(input logic [7:0] ch, input logic [5:0] at);
        int n;
        send(ch, at);
        wait_idle(n);
        settle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        for (int a = 0; a < CELLS; a++) ram[a] = 16'hA5A5;

        // Reset state
        repeat (3) tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);

        m_clear();
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        wait_idle(n);
        chk("init_busy_cycles", 32'(n), 32'd1202);
        settle();
        chk("init_cell0", 32'(ram[0]), 32'h4000);
        chk("init_ready", 32'(char_ready), 32'd1);

        // 'A' white+intensity
        put(8'h41, 6'b001111);
        chk("A_cell0", 32'(ram[0]), 32'h0F41);
        chk("A_cell1", 32'(ram[1]), 32'h4000);
        chk("A_col", 32'(cursor_col), 32'd1);
        chk("A_row", 32'(cursor_row), 32'd0);

        // Unassigned control byte: no RAM activity
        base = wr_cnt;
        put(8'h07, 6'd0);
        chk("bel_no_write", 32'(wr_cnt - base), 32'd0);
        chk("bel_col", 32'(cursor_col), 32'd1);

        // Form feed
        send(8'h0C, 6'd0);
        wait_idle(n);
        settle();
        chk("ff_busy_cycles", 32'(n), 32'd1202);
        chk("ff_col", 32'(cursor_col), 32'd0);
        chk("ff_cell0", 32'(ram[0]), 32'h4000);

        // 40 printable bytes wrap to the next line
        for (int i = 0; i < COLS; i++) put(8'h41 + 8'(i % 26), 6'(i));
        chk("wrap_cell39", 32'(ram[39]), 32'h274E);
        chk("wrap_cell40", 32'(ram[40]), 32'h4000);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);

        // Cell 40 = 0x0F42, walk down to the last row, then scroll
        put(8'h42, 6'b001111);
        chk("B_cell40", 32'(ram[40]), 32'h0F42);
        for (int i = 0; i < 28; i++) put(8'h0A, 6'd0);
        chk("lf_row29", 32'(cursor_row), 32'd29);
        chk("lf_col1", 32'(cursor_col), 32'd1);
        send(8'h0A, 6'd0);
        wait_idle(n);
        settle();
        chk("scroll_busy_ge_2360", 32'(n >= 2360), 32'd1);
        chk("scroll_cell0", 32'(ram[0]), 32'h0F42);
        chk("scroll_cell1", 32'(ram[1]), 32'h0000);
        for (int a = CELLS - COLS; a < CELLS; a++)
            chk($sformatf("scroll_blank_%0d", a), 32'(ram[a]), (a == CELLS - COLS + 1) ? 32'h4000 : 32'h0000);
        chk("scroll_row", 32'(cursor_row), 32'd29);
        chk("scroll_col", 32'(cursor_col), 32'd1);

        // "AB", BS, CR
        put(8'h0C, 6'd0);
        put(8'h41, 6'b001111);
        put(8'h42, 6'b001111);
        put(8'h08, 6'd0);
        chk("bs_cell1", 32'(ram[1]), 32'h4000);
        chk("bs_cell2", 32'(ram[2]), 32'h0000);
        chk("bs_col", 32'(cursor_col), 32'd1);
        put(8'h0D, 6'd0);
        chk("cr_cell1", 32'(ram[1]), 32'h0000);
        chk("cr_cell0", 32'(ram[0]), 32'h4F41);
        chk("cr_col", 32'(cursor_col), 32'd0);
        base = wr_cnt;
        put(8'h08, 6'd0);
        chk("bs_col0_no_write", 32'(wr_cnt - base), 32'd0);
        chk("bs_col0_col", 32'(cursor_col), 32'd0);

        // Move mid-screen, FF, then reset at the 500th clear write
        put(8'h0A, 6'd0);
        put(8'h0A, 6'd0);
        put(8'h78, 6'd3);
        chk("mid_row", 32'(cursor_row), 32'd2);
        chk("mid_col", 32'(cursor_col), 32'd1);
        base = wr_cnt;
        send(8'h0C, 6'd0);
        n = 0;
        while (wr_cnt < base + 500 && n < 2000) begin
            tick();
            n++;
        end
        chk("clear_500_reached", 32'(wr_cnt - base), 32'd500);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_col", 32'(cursor_col), 32'd0);
        chk("abort_row", 32'(cursor_row), 32'd0);
        exp_q.delete();
        m_clear();
        repeat (3) tick();
        base = wr_cnt;
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
        wait_idle(n);
        settle();
        chk("restart_busy_cycles", 32'(n), 32'd1202);
        chk("restart_writes", 32'(wr_cnt - base), 32'd1201);
        chk("restart_cell0", 32'(ram[0]), 32'h4000);
        chk("restart_col", 32'(cursor_col), 32'd0);
        chk("restart_row", 32'(cursor_row), 32'd0);
        chk("restart_ready", 32'(char_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
